// File: rtl/uart_pkg.sv
// Shared constants and helpers for the serial console transmit path.
package uart_pkg;

   localparam int NCH_MAX = 8;
   localparam int BYTE_W  = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Per-channel byte FIFO with combinational head and registered flags.
module uart_byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic              empty_q, full_q;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == '0);
         full_q  <= (cnt_d == FULL_CNT);
      end
   end

   // Storage needs no reset; pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wptr_q] <= din;
   end

   assign dout  = mem_q[rptr_q];
   assign empty = empty_q;
   assign full  = full_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin transmit scheduler feeding the shared UART/PS2 byte bus.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DEPTH = 8,
   parameter int HOLD  = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [clog2(NCH)-1:0]  wr_ch,
   input  logic [BYTE_W-1:0]      wr_data,
   input  logic [NCH-1:0]         flush,
   input  logic [NCH-1:0]         tx_busy,
   output logic [BYTE_W-1:0]      tx_data,
   output logic [NCH-1:0]         tx_wr,
   output logic [NCH-1:0]         fifo_empty,
   output logic [NCH-1:0]         fifo_full,
   output logic [NCH-1:0]         overflow
);

   localparam int CHW = clog2(NCH);

   logic [NCH-1:0][BYTE_W-1:0] dout;
   logic [NCH-1:0]             push, pop, elig, ovf_set;
   logic [NCH-1:0][1:0]        hold_q, hold_d;
   logic [CHW-1:0]             rr_q, rr_d;
   logic [CHW-1:0]             gnt_idx;
   logic                       gnt_found;
   logic                       wr_ok;
   logic [BYTE_W-1:0]          tx_data_q, tx_data_d;
   logic [NCH-1:0]             tx_wr_q, tx_wr_d;
   logic [NCH-1:0]             ovf_q, ovf_d;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      uart_byte_fifo #(
         .DEPTH(DEPTH)
      ) u_fifo (
         .clk   (clk),
         .reset (reset),
         .push  (push[i]),
         .pop   (pop[i]),
         .flush (flush[i]),
         .din   (wr_data),
         .dout  (dout[i]),
         .empty (fifo_empty[i]),
         .full  (fifo_full[i])
      );

      assign elig[i] = !fifo_empty[i] && !tx_busy[i]
                    && (hold_q[i] == 2'd0) && !flush[i];
   end

   // Search starts just past the last grant so every channel gets a turn.
   always_comb begin
      int c;
      c         = 0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 1; k <= NCH; k++) begin
         c = (int'(rr_q) + k) % NCH;
         if (!gnt_found && elig[c]) begin
            gnt_found = 1'b1;
            gnt_idx   = CHW'(c);
         end
      end
   end

   always_comb begin
      pop       = '0;
      push      = '0;
      ovf_set   = '0;
      tx_wr_d   = '0;
      tx_data_d = tx_data_q;
      rr_d      = rr_q;
      wr_ok     = wr_en && (32'(wr_ch) < NCH);
      if (gnt_found) begin
         pop[gnt_idx]     = 1'b1;
         tx_wr_d[gnt_idx] = 1'b1;
         tx_data_d        = dout[gnt_idx];
         rr_d             = gnt_idx;
      end
      for (int i = 0; i < NCH; i++) begin
         if (wr_ok && wr_ch == CHW'(i) && !flush[i]) begin
            if (!fifo_full[i] || pop[i]) push[i]    = 1'b1;
            else                         ovf_set[i] = 1'b1;
         end
      end
      ovf_d = (ovf_q | ovf_set) & ~flush;
   end

   always_comb begin
      hold_d = hold_q;
      for (int i = 0; i < NCH; i++) begin
         if (pop[i])                hold_d[i] = 2'(HOLD);
         else if (hold_q[i] != '0)  hold_d[i] = hold_q[i] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q    <= '0;
         rr_q      <= CHW'(NCH - 1);
         tx_data_q <= '0;
         tx_wr_q   <= '0;
         ovf_q     <= '0;
      end else begin
         hold_q    <= hold_d;
         rr_q      <= rr_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
         ovf_q     <= ovf_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_wr    = tx_wr_q;
   assign overflow = ovf_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler for the multi-channel serial console bank. It holds a small byte FIFO per channel and drives the single shared `tx_data` byte bus plus one-hot `tx_wr` strobes into the UART/PS2 engines. It grants the bus round-robin among channels that have data and whose engine is not busy, so the CPU can burst bytes without polling `tx_busy`. It sits between the Wishbone peripheral decoder (write side) and the serial engines.

## Interface
- `NCH`, default 4: number of channels, 2..8.
- `DEPTH`, default 8: FIFO entries per channel, power of two, at least 2.
- `HOLD`, default 2: cycles a channel stays ineligible after a grant, covering the `tx_busy` rise latency; 1..3.
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high; clock clk.
- `wr_en`, in, 1: enqueue strobe.
- `wr_ch`, in, clog2(NCH): target channel of `wr_en`.
- `wr_data`, in, 8: byte to enqueue.
- `flush`, in, NCH: per-channel FIFO clear.
- `tx_busy`, in, NCH: engine busy flags.
- `tx_data`, out, 8: shared byte bus, registered.
- `tx_wr`, out, NCH: one-hot write strobe, registered, 1-cycle pulse.
- `fifo_empty`, out, NCH: per-channel empty, registered.
- `fifo_full`, out, NCH: per-channel full, registered.
- `overflow`, out, NCH: sticky flag, set by a write to a full FIFO.

## Operation
- Reset values: all outputs are 0, except `fifo_empty`, which is all 1s. Pointers and counts are 0, holdoff counters are 0, and the round-robin pointer is NCH-1, so channel 0 has first priority.
- Enqueue:
  - `wr_en` with `fifo_full[wr_ch]`=0 stores `wr_data` at the write pointer, then increments the pointer (mod DEPTH) and the count.
  - If the FIFO is full, the byte is dropped and `overflow[wr_ch]` is set.
  - A `wr_ch` value of NCH or above is ignored.
- Eligibility of channel i: FIFO non-empty, `tx_busy[i]`=0, `hold_cnt[i]`=0, and `flush[i]`=0.
- Grant:
  - Each cycle, search eligible channels starting at rr_ptr+1 and wrapping; pick the first.
  - On a grant to channel g:
    - next cycle `tx_data` = FIFO[g] head and `tx_wr` = one-hot(g);
    - pop the head;
    - set rr_ptr = g and `hold_cnt[g]` = HOLD.
  - Otherwise next cycle `tx_wr` = 0 and `tx_data` holds its previous value.
- At most one grant per cycle. Grants to different channels may occur on back-to-back cycles.
- `hold_cnt` decrements to 0 every cycle it is non-zero.
- Simultaneous enqueue and pop on the same channel: both take effect and the count is unchanged. This is legal when full, because the pop frees the slot in the same cycle, so no overflow.
- Flush:
  - `flush[i]` zeroes the pointers and count of channel i and clears `overflow[i]`.
  - It beats a same-cycle write to i (byte dropped, no overflow) and blocks a same-cycle grant to i.
  - `hold_cnt[i]` is unaffected.
- Reset mid-operation: any pending `tx_wr` is suppressed on the next edge and all FIFO contents are discarded.

## Timing
- Latency, write to strobe:
  - byte written at edge E0 into an empty FIFO of an idle, unheld channel;
  - grant decided in the cycle after E0;
  - `tx_wr` high in the cycle after edge E1.
- `fifo_empty` and `fifo_full` reflect state after each edge. The flag update is visible one cycle after the causing write or pop.
- Write-side users must check `fifo_full` themselves. The block does not backpressure.
- Same-channel issue spacing is at least HOLD+1 cycles. After that, `tx_busy` gates further issue.
- Count width is clog2(DEPTH)+1 so that full and empty are distinct. Pointer width is clog2(DEPTH), with natural wrap.

## Structure
- Shared package `uart_pkg`: `NCH_MAX`=8, the byte width constant 8, and a `clog2` function.
- One sub-module `uart_byte_fifo`:
  - parameter DEPTH;
  - ports: push, pop, flush, din, dout (head, combinational), empty, full;
  - instantiated NCH times with a generate loop.
- The round-robin picker, holdoff counters and output registers stay in the top module.

## Test plan
- Reset:
  - assert reset 3 cycles, then release;
  - expect `tx_wr`=0, `fifo_empty`=all 1s, `fifo_full`=0, `overflow`=0.
- Single byte:
  - write 0x41 to ch1 at E0, `tx_busy`=0;
  - expect `tx_wr`=4'b0010 and `tx_data`=0x41 in the cycle after E1, for exactly one cycle;
  - expect `fifo_empty[1]` to return to 1.
- Round robin:
  - preload ch0={0x10,0x11}, ch2={0x20}, ch3={0x30} with `tx_busy` low;
  - expect strobe order ch0:0x10, ch2:0x20, ch3:0x30, ch0:0x11 on consecutive cycles.
- Busy gating:
  - hold `tx_busy[2]`=1 with ch2={0x55};
  - expect no strobe on ch2 until 1 cycle after `tx_busy[2]` falls.
- Full and overflow:
  - write 9 bytes 0x00..0x08 to ch3 while `tx_busy[3]`=1;
  - expect `fifo_full[3]`=1 and `overflow[3]`=1;
  - release busy and expect 0x00..0x07 transmitted, 0x08 absent.
- Flush collision:
  - `flush[0]` in the same cycle as a write of 0xAA to ch0, with ch0 holding 3 bytes;
  - expect ch0 empty, no strobe, and `overflow[0]`=0.
